fft_stage_sequencer: RTL and testbench

//  Control sequencer for the in-place radix-2 DIF FFT engine. After a start pulse it

---
 rtl/fft_stage_sequencer_pkg.sv | 23 ++
 rtl/fft_addr_delay.sv | 26 ++
 rtl/fft_stage_sequencer.sv | 129 ++++++++++++
 tb/tb_fft_stage_sequencer.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/fft_stage_sequencer_pkg.sv
// Shared definitions for the radix-2 DIF FFT stage sequencer: FSM states,
// default geometry and the stage-index width helper.
package fft_stage_sequencer_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam int unsigned DEF_LOG2N    = 4;
  localparam int unsigned DEF_BFLY_LAT = 2;

  // Bits needed to hold a stage index 0..log2n-1, never less than one.
  function automatic int unsigned stage_w(input int unsigned log2n);
    int unsigned w;
    w = 1;
    while ((32'd1 << w) < log2n) w++;
    return w;
  endfunction

endpackage

// File: rtl/fft_addr_delay.sv
// DEPTH x WIDTH shift register with asynchronous active-low clear; carries
// issue strobe and read addresses forward to the write-back side.
module fft_addr_delay #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 9
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] pipe [DEPTH];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= d;
      for (int unsigned i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign q = pipe[DEPTH-1];

endmodule

// File: rtl/fft_stage_sequencer.sv
// Control sequencer for the in-place radix-2 DIF FFT: issues N/2 butterflies
// per stage for LOG2N stages and replays their addresses as write-backs.
module fft_stage_sequencer
  import fft_stage_sequencer_pkg::*;
#(
  parameter int unsigned LOG2N    = DEF_LOG2N,
  parameter int unsigned BFLY_LAT = DEF_BFLY_LAT
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic                        stall,
  output logic                        busy,
  output logic                        done,
  output logic [stage_w(LOG2N)-1:0]   stage,
  output logic                        rd_en,
  output logic [LOG2N-1:0]            rd_addr_a,
  output logic [LOG2N-1:0]            rd_addr_b,
  output logic [LOG2N-2:0]            tw_addr,
  output logic                        wr_en,
  output logic [LOG2N-1:0]            wr_addr_a,
  output logic [LOG2N-1:0]            wr_addr_b
);

  localparam int unsigned SW = stage_w(LOG2N);
  localparam int unsigned KW = LOG2N - 1;
  localparam int unsigned N  = 32'd1 << LOG2N;
  localparam int unsigned DW = 1 + 2 * LOG2N;

  state_t            state, state_nx;
  logic [KW-1:0]     k;
  logic [SW-1:0]     stage_q;
  logic [2:0]        dcnt;
  logic              issue, busy_nx, done_nx;
  logic              k_last, drain_last, stage_last;
  logic              busy_q, done_q, rd_en_q;
  logic [LOG2N-1:0]  a_q, b_q, a_nx, b_nx;
  logic [KW-1:0]     tw_q, tw_nx;
  logic [DW-1:0]     dly_q;
  int unsigned       s_i, k_i, half, grp, idx, a_i;

  assign k_last     = (k == '1);
  assign drain_last = (dcnt == 3'(BFLY_LAT - 1));
  assign stage_last = (stage_q == SW'(LOG2N - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nx;
  end

  // A start seen while done is still showing is the tail of the previous run.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start && !done_q) state_nx = S_RUN;
      S_RUN:   if (issue && k_last) state_nx = S_DRAIN;
      S_DRAIN: if (drain_last) state_nx = stage_last ? S_DONE : S_RUN;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    issue   = (state == S_RUN) && !stall;
    busy_nx = (state == S_RUN) || (state == S_DRAIN);
    done_nx = (state == S_DONE);
  end

  // grp*2*half + idx places the butterfly pair within its group.
  always_comb begin
    s_i   = 32'(stage_q);
    k_i   = 32'(k);
    half  = N >> (s_i + 1);
    grp   = k_i >> (LOG2N - 1 - s_i);
    idx   = k_i & (half - 1);
    a_i   = grp * 2 * half + idx;
    a_nx  = LOG2N'(a_i);
    b_nx  = LOG2N'(a_i + half);
    tw_nx = KW'(idx << s_i);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      k       <= '0;
      stage_q <= '0;
      dcnt    <= '0;
      rd_en_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      tw_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      rd_en_q <= issue;
      busy_q  <= busy_nx;
      done_q  <= done_nx;
      if (issue) begin
        a_q  <= a_nx;
        b_q  <= b_nx;
        tw_q <= tw_nx;
        k    <= k + 1'b1;
      end
      dcnt <= (state == S_DRAIN) ? dcnt + 3'd1 : '0;
      if (state == S_DRAIN && drain_last)
        stage_q <= stage_last ? '0 : stage_q + 1'b1;
    end
  end

  fft_addr_delay #(
    .DEPTH (BFLY_LAT),
    .WIDTH (DW)
  ) u_wb_delay (
    .clk   (clk),
    .reset (reset),
    .d     ({rd_en_q, a_q, b_q}),
    .q     (dly_q)
  );

  assign {wr_en, wr_addr_a, wr_addr_b} = dly_q;

  assign busy      = busy_q;
  assign done      = done_q;
  assign stage     = stage_q;
  assign rd_en     = rd_en_q;
  assign rd_addr_a = a_q;
  assign rd_addr_b = b_q;
  assign tw_addr   = tw_q;

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Scoreboard bench for fft_stage_sequencer at default geometry (N=16, latency 2).
module tb_fft_stage_sequencer;

  localparam int LOG2N = 4;
  localparam int LAT   = 2;
  localparam int H     = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       stall = 1'b0;
  logic       busy, done, rd_en, wr_en;
  logic [1:0] stage;
  logic [3:0] rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b;
  logic [2:0] tw_addr;

  typedef struct {
    int s;
    int k;
    int a;
    int b;
    int tw;
  } bf_t;

  bf_t   rd_q[$];
  bf_t   wr_q[$];
  int    total = 0;
  int    bad = 0;
  int    n_rd = 0;
  logic [15:0] wmask [LOG2N];

  int hs[3]  = '{0, 1, 3};
  int hk[3]  = '{3, 5, 7};
  int ha[3]  = '{3, 9, 14};
  int hb[3]  = '{11, 13, 15};
  int htw[3] = '{3, 2, 0};

  fft_stage_sequencer #(.LOG2N(LOG2N), .BFLY_LAT(LAT)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .stall     (stall),
    .busy      (busy),
    .done      (done),
    .stage     (stage),
    .rd_en     (rd_en),
    .rd_addr_a (rd_addr_a),
    .rd_addr_b (rd_addr_b),
    .tw_addr   (tw_addr),
    .wr_en     (wr_en),
    .wr_addr_a (wr_addr_a),
    .wr_addr_b (wr_addr_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Bit-insertion view: a has a 0 inserted at bit LOG2N-1-s of k, b a 1.
  function automatic bf_t model(input int s, input int k);
    bf_t m;
    int p, lo, hi;
    p    = LOG2N - 1 - s;
    lo   = k & ((1 << p) - 1);
    hi   = k >> p;
    m.s  = s;
    m.k  = k;
    m.a  = (hi << (p + 1)) | lo;
    m.b  = m.a | (1 << p);
    m.tw = (k << s) & (H - 1);
    return m;
  endfunction

  task automatic push_run();
    for (int s = 0; s < LOG2N; s++)
      for (int k = 0; k < H; k++) begin
        rd_q.push_back(model(s, k));
        wr_q.push_back(model(s, k));
      end
  endtask

  // mode 0: plain; 1: stall in DRAIN and 3 cycles mid-stage 1; 2: stray starts
  task automatic run(input int mode, input int exp_done);
    int first_busy, last_busy, done_c, rd0;
    first_busy = -1; last_busy = -1; done_c = -1;
    for (int s = 0; s < LOG2N; s++) wmask[s] = '0;
    push_run();
    rd0 = n_rd;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c <= exp_done + 8; c++) begin
      @(posedge clk); #1;
      if (busy) begin
        if (first_busy < 0) first_busy = c;
        last_busy = c;
      end
      if (done && done_c < 0) done_c = c;
      stall = (mode == 1) && (c == 8 || (c >= 12 && c <= 14));
      start = (mode == 2) && (c == 5 || c == exp_done);
    end
    start = 1'b0;
    stall = 1'b0;
    chk("busy_first", first_busy, 1);
    chk("busy_last", last_busy, exp_done - 1);
    chk("done_cycle", done_c, exp_done);
    chk("rd_count", n_rd - rd0, 32);
    chk("rd_q_left", rd_q.size(), 0);
    chk("wr_q_left", wr_q.size(), 0);
    for (int s = 0; s < LOG2N; s++) chk("wr_cover", int'(wmask[s]), 16'hFFFF);
  endtask

  initial begin : monitor
    logic h_en [LAT];
    int   h_a [LAT];
    int   h_b [LAT];
    bf_t  e;
    for (int i = 0; i < LAT; i++) begin h_en[i] = 1'b0; h_a[i] = 0; h_b[i] = 0; end
    forever begin
      @(negedge clk);
      if (!reset) begin
        for (int i = 0; i < LAT; i++) h_en[i] = 1'b0;
        continue;
      end
      if (rd_en) begin
        n_rd++;
        if (rd_q.size() == 0) chk("rd_unexpected", 1, 0);
        else begin
          e = rd_q.pop_front();
          chk("rd_stage", int'(stage), e.s);
          chk("rd_addr_a", int'(rd_addr_a), e.a);
          chk("rd_addr_b", int'(rd_addr_b), e.b);
          chk("tw_addr", int'(tw_addr), e.tw);
          for (int j = 0; j < 3; j++)
            if (e.s == hs[j] && e.k == hk[j]) begin
              chk("vec_a", int'(rd_addr_a), ha[j]);
              chk("vec_b", int'(rd_addr_b), hb[j]);
              chk("vec_tw", int'(tw_addr), htw[j]);
            end
        end
      end
      if (wr_en) begin
        if (wr_q.size() == 0) chk("wr_unexpected", 1, 0);
        else begin
          e = wr_q.pop_front();
          chk("wr_addr_a", int'(wr_addr_a), e.a);
          chk("wr_addr_b", int'(wr_addr_b), e.b);
          wmask[e.s] = wmask[e.s] | (16'd1 << e.a) | (16'd1 << e.b);
        end
      end
      if (wr_en || h_en[LAT-1]) begin
        chk("wr_en_delay", int'(wr_en), int'(h_en[LAT-1]));
        if (wr_en) begin
          chk("wr_a_delay", int'(wr_addr_a), h_a[LAT-1]);
          chk("wr_b_delay", int'(wr_addr_b), h_b[LAT-1]);
        end
      end
      for (int i = LAT - 1; i > 0; i--) begin
        h_en[i] = h_en[i-1]; h_a[i] = h_a[i-1]; h_b[i] = h_b[i-1];
      end
      h_en[0] = rd_en; h_a[0] = int'(rd_addr_a); h_b[0] = int'(rd_addr_b);
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "timeout");
  end

  initial begin : stim
    #12;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_rd_en", int'(rd_en), 0);
    chk("rst_wr_en", int'(wr_en), 0);
    chk("rst_stage", int'(stage), 0);
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    run(0, 41);
    run(1, 44);
    run(2, 41);
    run(0, 41);

    // reset while stage 1 drains, with a write-back still in flight
    push_run();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (19) @(posedge clk);
    #1;
    chk("pre_rst_wr_en", int'(wr_en), 1);
    reset = 1'b0;
    #1;
    chk("arst_busy", int'(busy), 0);
    chk("arst_rd_en", int'(rd_en), 0);
    chk("arst_wr_en", int'(wr_en), 0);
    chk("arst_wr_a", int'(wr_addr_a), 0);
    chk("arst_stage", int'(stage), 0);
    rd_q.delete();
    wr_q.delete();
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
      chk("post_rst_wr_en", int'(wr_en), 0);
      chk("post_rst_busy", int'(busy), 0);
    end

    run(0, 41);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
